// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter and sequencer for the single-ported program/data RAM.
// The CPU and DMA ports each run a req/ack handshake; one transaction owns the RAM at a time.
module mem_arbiter #(
   parameter int ADDR_W  = 8,
   parameter int DATA_W  = 8,
   parameter int MEM_LAT = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic              cpu_lock,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_gnt,
   output logic              cpu_ack,
   output logic [DATA_W-1:0] cpu_rdata,
   input  logic              dma_req,
   input  logic              dma_we,
   input  logic              dma_lock,
   input  logic [ADDR_W-1:0] dma_addr,
   input  logic [DATA_W-1:0] dma_wdata,
   output logic              dma_gnt,
   output logic              dma_ack,
   output logic [DATA_W-1:0] dma_rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy
);

   typedef enum logic [1:0] {IDLE, ACCESS, ACK} state_e;
   typedef enum logic [1:0] {OWN_NONE, OWN_CPU, OWN_DMA} owner_e;

   localparam logic [3:0] LAST_CNT = 4'(MEM_LAT - 1);

   state_e              state_q, state_d;
   owner_e              owner_q, owner_d;
   logic [3:0]          cnt_q, cnt_d;
   logic                lastDma_q, lastDma_d;
   logic                lockHold_q, lockHold_d;
   logic                we_q, we_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [DATA_W-1:0]   cpuRdata_q, cpuRdata_d;
   logic [DATA_W-1:0]   dmaRdata_q, dmaRdata_d;
   logic                winDma;
   logic                lockedReq;

   // A held lock always belongs to the previous owner; it only matters when both ports ask.
   always_comb begin
      lockedReq = lastDma_q ? dma_req : cpu_req;
      if (cpu_req && dma_req) begin
         winDma = lockHold_q ? lastDma_q : !lastDma_q;
      end else begin
         winDma = dma_req;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         owner_q    <= OWN_NONE;
         cnt_q      <= '0;
         lastDma_q  <= 1'b1;
         lockHold_q <= 1'b0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         cpuRdata_q <= '0;
         dmaRdata_q <= '0;
      end else begin
         state_q    <= state_d;
         owner_q    <= owner_d;
         cnt_q      <= cnt_d;
         lastDma_q  <= lastDma_d;
         lockHold_q <= lockHold_d;
         we_q       <= we_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         cpuRdata_q <= cpuRdata_d;
         dmaRdata_q <= dmaRdata_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      owner_d    = owner_q;
      cnt_d      = cnt_q;
      lastDma_d  = lastDma_q;
      lockHold_d = lockHold_q;
      we_d       = we_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      cpuRdata_d = cpuRdata_q;
      dmaRdata_d = dmaRdata_q;
      case (state_q)
         IDLE: begin
            lockHold_d = lockHold_q && lockedReq && (winDma == lastDma_q);
            if (cpu_req || dma_req) begin
               state_d = ACCESS;
               cnt_d   = '0;
               owner_d = winDma ? OWN_DMA : OWN_CPU;
               we_d    = winDma ? dma_we : cpu_we;
               addr_d  = winDma ? dma_addr : cpu_addr;
               wdata_d = winDma ? dma_wdata : cpu_wdata;
            end
         end
         ACCESS: begin
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == LAST_CNT) begin
               state_d = ACK;
               if (!we_q) begin
                  if (owner_q == OWN_DMA) begin
                     dmaRdata_d = mem_rdata;
                  end else begin
                     cpuRdata_d = mem_rdata;
                  end
               end
            end
         end
         ACK: begin
            state_d    = IDLE;
            owner_d    = OWN_NONE;
            lastDma_d  = (owner_q == OWN_DMA);
            lockHold_d = (owner_q == OWN_DMA) ? dma_lock : cpu_lock;
         end
         default: state_d = IDLE;
      endcase
   end

   // Every output is a decode of registered state, so no input-to-output paths exist.
   always_comb begin
      busy      = (state_q != IDLE);
      mem_en    = (state_q == ACCESS);
      mem_we    = (state_q == ACCESS) && we_q;
      mem_addr  = addr_q;
      mem_wdata = wdata_q;
      cpu_gnt   = (state_q != IDLE) && (owner_q == OWN_CPU);
      dma_gnt   = (state_q != IDLE) && (owner_q == OWN_DMA);
      cpu_ack   = (state_q == ACK) && (owner_q == OWN_CPU);
      dma_ack   = (state_q == ACK) && (owner_q == OWN_DMA);
      cpu_rdata = cpuRdata_q;
      dma_rdata = dmaRdata_q;
   end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-port arbiter and sequencer for the single-ported 8-bit program/data RAM.
- Shares the RAM between the CPU memory port and a DMA/program-loader port.
- Each requester runs a req/ack handshake; the block grants one requester at a time and owns all RAM control strobes.
- Ties are broken round-robin. An optional lock keeps ownership for back-to-back bursts, e.g. a loader filling RAM while the CPU is held off.

Parameters:
- ADDR_W, 8, address width of both ports and the RAM.
- DATA_W, 8, data width.
- MEM_LAT, 2, number of ACCESS cycles per transaction; RAM read data is sampled in the last one; legal range 1..15.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- cpu_req  in  1  CPU transaction request; held until cpu_ack.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_lock  in  1  request to retain ownership for the next transaction.
- cpu_addr  in  ADDR_W  CPU address.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_gnt  out  1  CPU owns RAM (ACCESS and ACK states).
- cpu_ack  out  1  one-cycle completion pulse.
- cpu_rdata  out  DATA_W  registered read data, valid from cpu_ack onward.
- dma_req, dma_we, dma_lock, dma_addr, dma_wdata, dma_gnt, dma_ack, dma_rdata: same as the CPU equivalents, for the DMA port.
- mem_en  out  1  RAM access strobe.
- mem_we  out  1  RAM write strobe.
- mem_addr  out  ADDR_W  RAM address.
- mem_wdata  out  DATA_W  RAM write data.
- mem_rdata  in  DATA_W  RAM read data.
- busy  out  1  high when the FSM is not in IDLE.

Behaviour:
- States: IDLE, ACCESS, ACK. All outputs are registered or decoded from registered state.
- Reset:
  - State = IDLE, cnt = 0, owner = none, last_owner = DMA (so the CPU wins the first tie), lock_hold = 0.
  - All outputs are 0, including rdata registers and mem_addr/mem_wdata.
  - Reset applied mid-transaction aborts it: no ack is issued and mem_en drops on the next cycle.
- IDLE arbitration (cycle t):
  - If exactly one req is high, that requester wins.
  - If both are high and lock_hold is set for requester X with X's req high, X wins.
  - Otherwise the requester that is not last_owner wins.
  - On a win, at the edge ending t: latch addr, we and wdata from the winner, set owner, go to ACCESS, cnt = 0.
  - If no req is high, stay in IDLE.
- ACCESS (cycles t+1 .. t+MEM_LAT):
  - mem_en = 1; mem_we = latched we; mem_addr/mem_wdata = latched values, stable for the whole window.
  - The owner's gnt = 1.
  - cnt increments each cycle. When cnt == MEM_LAT-1: capture mem_rdata into the owner's rdata register (reads only; writes leave rdata unchanged), then go to ACK.
- ACK (cycle t+MEM_LAT+1):
  - Owner's ack = 1 and gnt = 1; mem_en = mem_we = 0.
  - last_owner <= owner.
  - lock_hold <= owner's lock sampled this cycle.
  - Next state is IDLE.
- Total latency: req first seen in IDLE at cycle t → ack at t+MEM_LAT+1. Back-to-back transactions repeat every MEM_LAT+2 cycles.
- A req still high in the IDLE cycle after ack is treated as a new request. Requesters deassert req in the ack cycle to avoid a duplicate transaction.
- Requester inputs are ignored outside IDLE:
  - Dropping req during ACCESS does not cancel the transaction; the ack still fires.
  - Changing addr or data during ACCESS has no effect.
- lock_hold only overrides a tie. It is cleared whenever the non-locked requester wins, and when the locked requester's req is low in IDLE.
- The ack pulse is exactly one cycle. gnt is never high on both ports; ack is never high on both ports.
- mem_en and mem_we are never high in IDLE or ACK.
- mem_addr and mem_wdata hold their last latched value in IDLE.

Test Plan:
- CPU read, MEM_LAT=2: cpu_req=1, addr=0x10, RAM[0x10]=0xA5 at t0 → mem_en high t1–t2, mem_addr=0x10, cpu_ack at t3 only, cpu_rdata=0xA5 from t3; dma_gnt stays 0.
- Tie after reset: both req at t0 → CPU served first (ack t3). DMA is granted at t4 (IDLE) and acked at t7, even with cpu_req held high. Then the CPU wins the next tie.
- Lock burst: dma_lock=1 on three consecutive DMA writes (0x00←0x11, 0x01←0x22, 0x02←0x33) with cpu_req continuously high → the three DMA transactions complete first with mem_we high during ACCESS; the CPU is granted after dma_lock drops.
- Write leaves rdata: after a CPU read returning 0x5A, a CPU write of 0xFF to 0x20 → RAM[0x20]=0xFF and cpu_rdata remains 0x5A.
- Reset mid-access: reset asserted in the first ACCESS cycle → next cycle busy=0, mem_en=0, no ack. A CPU-vs-DMA tie after release is granted to the CPU.
- Req drop and MEM_LAT=1: dma_req pulsed for one cycle only → ACCESS lasts one cycle and dma_ack still pulses at t2 with the correct rdata.
